mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum number of BUSY cycles waiting for mem_ack (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port if_req  input  1  instruction-fetch request; held high until if_ready.
REQ-007 SHALL have port if_addr  input  ADDR_WIDTH  instruction-fetch address.
REQ-008 SHALL have port if_rdata  output  DATA_WIDTH  fetched instruction, valid while if_ready is high.
REQ-009 SHALL have port if_ready  output  1  one-cycle completion pulse for the fetch port.
REQ-010 SHALL have port d_req  input  1  data request; held high until d_ready.
REQ-011 SHALL have port d_we  input  1  data write enable (1 = store, 0 = load).
REQ-012 SHALL have port d_addr  input  ADDR_WIDTH  data address.
REQ-013 SHALL have port d_wdata  input  DATA_WIDTH  store data.
REQ-014 SHALL have port d_rdata  output  DATA_WIDTH  load data, valid while d_ready is high.
REQ-015 SHALL have port d_ready  output  1  one-cycle completion pulse for the data port.
REQ-016 SHALL have port mem_req  output  1  request to the shared memory; held until mem_ack.
REQ-017 SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_WIDTH), mem_wdata (output, DATA_WIDTH)  registered copies of the granted request.
REQ-018 SHALL have ports mem_rdata (input, DATA_WIDTH) and mem_ack (input, 1)  memory response; mem_ack is a one-cycle pulse.
REQ-019 SHALL have port err  output  1  one-cycle pulse on timeout abort.

Function
REQ-020 SHALL implement the states IDLE, BUSY and DONE.
REQ-021 SHALL sample if_req and d_req only in IDLE.
REQ-022 In IDLE, if any request is high, SHALL register the grant, address, we and wdata, and enter BUSY on the next edge.
REQ-023 SHALL drive mem_req high during every BUSY cycle, with mem_we forced to 0 for fetch grants.
REQ-024 On mem_ack in BUSY, SHALL register mem_rdata into the granted port's rdata and enter DONE.
REQ-025 In DONE, SHALL assert the granted port's ready for exactly one cycle, then return to IDLE.
REQ-026 Minimum latency SHALL be req sampled at cycle 0, mem_req high at cycle 1, ack at cycle 1, ready at cycle 2, next sample at cycle 3.
REQ-027 A req still high in the IDLE cycle after DONE SHALL be treated as a new transaction.
REQ-028 if_rdata and d_rdata SHALL hold their last value outside ready cycles.
REQ-029 SHALL count BUSY cycles with an 8-bit counter that is cleared on entering BUSY.
REQ-030 If the counter reaches TIMEOUT without mem_ack, SHALL drop mem_req, pulse err for one cycle, return to IDLE, and assert no ready.
REQ-031 mem_ack arriving in IDLE or DONE SHALL be ignored.
REQ-032 mem_ack arriving on the same cycle the timeout is reached SHALL be treated as a successful completion.
REQ-033 Only one transaction SHALL be outstanding at a time; inputs that change in BUSY SHALL not alter mem_addr, mem_we or mem_wdata.

Reset
REQ-034 reset SHALL force IDLE, clear the counter and grant, and drive mem_req, mem_we, if_ready, d_ready and err to 0 on the next edge.
REQ-035 reset SHALL drive mem_addr, mem_wdata, if_rdata and d_rdata to 0.
REQ-036 reset asserted mid-BUSY SHALL abort the transaction with no ready and no err; a later stray mem_ack SHALL be ignored.
REQ-037 The round-robin pointer SHALL reset to favour the data port.

Configuration
REQ-038 The macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-039 Without ARB_ROUND_ROBIN_EN: the data port SHALL always win when both requests are high in IDLE.
REQ-040 With ARB_ROUND_ROBIN_EN: on a simultaneous request, SHALL grant the port not granted in the previous simultaneous contention, starting with data after reset.
REQ-041 With ARB_ROUND_ROBIN_EN: single-requester grants SHALL not move the round-robin pointer.

Verification
REQ-042 Fetch only, if_addr=0x8, memory acks 2 cycles after mem_req with 0x00100093 -> if_ready pulses once with if_rdata=0x00100093, and mem_we=0 throughout.
REQ-043 Store d_we=1, d_addr=0x4, d_wdata=0x6, then load 0x4 -> mem_we=1 with wdata 0x6 on the first transaction, and d_rdata=0x6 on the second d_ready.
REQ-044 if_req and d_req both high for 4 transactions -> without the macro, the grant order is D,D,D,D with the fetch port starved; with the macro, the order is D,I,D,I.
REQ-045 No mem_ack with TIMEOUT=15 -> mem_req drops after 15 BUSY cycles, err pulses once, no ready, and the next request is served normally.
REQ-046 reset asserted at the 2nd BUSY cycle, then mem_ack one cycle later -> all outputs are 0, state is IDLE, and no ready or err is generated.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one shared memory port with timeout
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise the data port always wins contention.
//
// Ports:
//   clk, reset                       single clock, synchronous active-high reset
//   if_req, if_addr                  fetch request (held until if_ready)
//   if_rdata, if_ready               fetch response (one-cycle ready pulse)
//   d_req, d_we, d_addr, d_wdata     data request (held until d_ready)
//   d_rdata, d_ready                 data response (one-cycle ready pulse)
//   mem_req, mem_we, mem_addr,
//   mem_wdata                        shared memory request (held until mem_ack)
//   mem_rdata, mem_ack               shared memory response (ack is a pulse)
//   err                              one-cycle pulse when a request times out
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Value of the BUSY-cycle counter during the last cycle allowed to wait.
    localparam logic [7:0] BUSY_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic       grant_d;      // 1: current transaction belongs to the data port
    logic [7:0] busy_cnt;
    logic       pick_d;
    logic       timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    // Port favoured on the next simultaneous request; only contention moves it.
    logic rr_d;

    always_comb pick_d = d_req & (~if_req | rr_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_d <= 1'b1;
        end else if (state == IDLE && if_req && d_req) begin
            rr_d <= ~rr_d;
        end
    end
`else
    always_comb pick_d = d_req;
`endif

    // An ack on the final allowed cycle wins over the timeout.
    always_comb timeout_hit = (state == BUSY) && !mem_ack && (busy_cnt == BUSY_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (if_req || d_req) state_nxt = BUSY;
            BUSY: begin
                if (mem_ack)          state_nxt = DONE;
                else if (timeout_hit) state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state == BUSY);
        if_ready = (state == DONE) && !grant_d;
        d_ready  = (state == DONE) && grant_d;
    end

    // Request capture, response capture, counter and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_d   <= 1'b0;
            busy_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            err <= timeout_hit;
            if (state == IDLE && (if_req || d_req)) begin
                grant_d   <= pick_d;
                busy_cnt  <= '0;
                mem_addr  <= pick_d ? d_addr : if_addr;
                mem_we    <= pick_d & d_we;
                mem_wdata <= pick_d ? d_wdata : '0;
            end
            if (state == BUSY) begin
                busy_cnt <= busy_cnt + 8'd1;
                if (mem_ack) begin
                    if (grant_d) d_rdata  <= mem_rdata;
                    else         if_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - timeline-model self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, err;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Timeline of the transaction in flight, in bench cycle numbers.
    int          req_first = -100, req_last = -101, ready_cyc = -1, err_cyc = -1;
    bit          ready_is_d;
    logic [31:0] resp_val, exp_addr, exp_wdata;
    bit          exp_we;
    logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
    bit          chk_en = 1'b0;
    bit          model_rr_d = 1'b1;
    logic [31:0] mem_model [logic [31:0]];

    function automatic bit model_pick(input bit ir, input bit dr);
        bit w;
        if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = model_rr_d;
            model_rr_d = ~model_rr_d;
`else
            w = 1'b1;
`endif
        end else begin
            w = dr;
        end
        return w;
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], 16'hF00D};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            int  n;
            bit  e_req;
            n = cyc;
            e_req = (n >= req_first) && (n <= req_last);
            check("mem_req", mem_req, e_req);
            if (e_req) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", mem_we, exp_we);
                if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (n == ready_cyc) begin
                if (ready_is_d) exp_d_rdata = resp_val;
                else            exp_if_rdata = resp_val;
            end
            check("if_ready", if_ready, (n == ready_cyc) && !ready_is_d);
            check("d_ready", d_ready, (n == ready_cyc) && ready_is_d);
            check("err", err, n == err_cyc);
            check("if_rdata", if_rdata, exp_if_rdata);
            check("d_rdata", d_rdata, exp_d_rdata);
        end
    end

    // One transaction: k = BUSY cycle index of the ack (k >= TO means no ack).
    task automatic run_txn(input bit ir, input bit dr, input bit we,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                           input int k, input bit hold, input bit extra_ack, output bit won_d);
        int          t0, c;
        logic [31:0] resp;
        @(posedge clk); #2;
        t0 = cyc;
        mem_ack = 1'b0;
        if_req = ir; d_req = dr; d_we = we; if_addr = ia; d_addr = da; d_wdata = wd;
        won_d = model_pick(ir, dr);
        exp_addr  = won_d ? da : ia;
        exp_we    = won_d & we;
        exp_wdata = wd;
        if (won_d && we) begin
            resp = 32'h0BAD_0000 ^ da;
            mem_model[da] = wd;
        end else begin
            resp = mem_read(exp_addr);
        end
        ready_is_d = won_d;
        resp_val   = resp;
        req_first  = t0 + 1;
        if (k < TO) begin
            req_last = t0 + 1 + k; ready_cyc = t0 + 2 + k; err_cyc = -1;
        end else begin
            req_last = t0 + TO;    ready_cyc = -1;         err_cyc = t0 + 1 + TO;
        end
        forever begin
            @(posedge clk); #2;
            c = cyc;
            mem_ack   = (k < TO && c == t0 + 1 + k) || (extra_ack && k < TO && c == t0 + 2 + k);
            mem_rdata = mem_ack ? resp : $urandom;
            if (c <= req_last) begin
                if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = $urandom;
            end
            if (k < TO) begin
                if (c == t0 + 2 + k) begin
                    if (!hold) begin if_req = 1'b0; d_req = 1'b0; end
                    break;
                end
            end else begin
                if (c == t0 + TO) begin if_req = 1'b0; d_req = 1'b0; end
                if (c == t0 + 1 + TO) break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #2; mem_ack = 1'b0; end
    endtask

    initial begin
        bit         w;
        logic [3:0] order;
        int         t0;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_readies", {if_ready, d_ready, err}, 0);
        check("rst_rdata", {if_rdata, d_rdata}, 0);
        chk_en = 1'b1;

        // Four back-to-back contended transactions.
        for (int i = 0; i < 4; i++) begin
            run_txn(1, 1, 0, 32'h100 + 32'(i * 4), 32'h200 + 32'(i * 4), 32'h0, i % 3, i != 3, 0, w);
            order[i] = w;
        end
`ifdef ARB_ROUND_ROBIN_EN
        check("contention_order", order, 4'b0101);
`else
        check("contention_order", order, 4'b1111);
`endif
        idle_cycles(1);

        // Fetch of a known instruction word, ack two cycles after mem_req.
        mem_model[32'h8] = 32'h0010_0093;
        run_txn(1, 0, 1, 32'h8, 32'h0, 32'h0, 2, 0, 0, w);
        @(negedge clk);
        check("fetch_word", if_rdata, 32'h0010_0093);

        // Store then load of the same word; a stray ack lands in DONE.
        run_txn(0, 1, 1, 32'h0, 32'h4, 32'h6, 0, 0, 1, w);
        run_txn(0, 1, 0, 32'h0, 32'h4, 32'h0, 0, 0, 0, w);
        @(negedge clk);
        check("load_after_store", d_rdata, 32'h6);

        // No ack: timeout, then a normal request.
        run_txn(1, 0, 0, 32'h44, 32'h0, 32'h0, 1000, 0, 0, w);
        run_txn(1, 0, 0, 32'h48, 32'h0, 32'h0, 1, 0, 0, w);
        // Ack on the very last allowed cycle completes normally.
        run_txn(0, 1, 0, 32'h0, 32'h4, 32'h0, TO - 1, 0, 0, w);
        idle_cycles(2);

        // Reset during the second BUSY cycle, stray ack afterwards.
        @(posedge clk); #2;
        t0 = cyc;
        if_req = 1'b1; d_req = 1'b0; if_addr = 32'h80;
        exp_addr = 32'h80; exp_we = 1'b0;
        req_first = t0 + 1; req_last = t0 + TO; ready_cyc = -1; err_cyc = -1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        reset = 1'b1; if_req = 1'b0; req_last = t0 + 2;
        @(posedge clk); #2;
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        exp_if_rdata = '0; exp_d_rdata = '0; model_rr_d = 1'b1;
        @(negedge clk);
        check("abort_mem_addr", mem_addr, 0);
        check("abort_mem_wdata", mem_wdata, 0);
        check("abort_mem_we", mem_we, 0);
        check("abort_rdata", {if_rdata, d_rdata}, 0);
        idle_cycles(4);

        // First contention after reset must go to the data port.
        run_txn(1, 1, 0, 32'h300, 32'h304, 32'h0, 0, 0, 0, w);
        check("rr_after_reset", w, 1);
        idle_cycles(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
